// File: rtl/flt_row_ctrl.sv
// flt_row_ctrl - row sequencer in front of the PNG filter datapath.
//
// For each scanline of an image it first emits one filter-type beat. It then
// streams that row's pixels to the filter, together with their left (a),
// up (b) and up-left (c) neighbours. It also drives the previous-row line
// buffer: every row except the last is written, and every row except the
// first is read back as the "up" row.
//
// Handshakes (valid/ready):
//   A beat on the flt_* side transfers on a cycle where flt_val_o and
//   flt_rdy_i are both high. flt_val_o never depends on a beat being
//   accepted. A source pixel is consumed exactly when pix_ack_o is high, which
//   in the ROW state equals pix_val_i & flt_rdy_i. The line-buffer strobes
//   (lb_wr_val_o, lb_rd_ack_o) are single-cycle qualifiers of that same
//   transfer. When flt_rdy_i is low, no beat moves and all state holds.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start_i            start an image (sampled only while idle)
//   cfg_w_i/h_i/flt_i  width-1, height-1, filter type (latched at start)
//   busy_o, done_o     image in progress / one-cycle completion pulse
//   pix_val_i/dat_i    source pixel stream, pix_ack_o = consumed
//   flt_*              beat to the filter: head flag, data, a/b/c neighbours
//   lb_wr_*            line buffer write strobe/data
//   lb_rd_ack_o/dat_i  line buffer read consume / head-of-buffer data
//   dbg_state_o        current FSM state (IDLE=0, HEAD=1, ROW=2, DONE=3)
module flt_row_ctrl #(
  parameter int DATA_WD   = 8,
  parameter int SIZE_W_WD = 12,
  parameter int SIZE_H_WD = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [SIZE_W_WD-1:0] cfg_w_i,
  input  logic [SIZE_H_WD-1:0] cfg_h_i,
  input  logic [2:0]           cfg_flt_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 pix_val_i,
  input  logic [DATA_WD-1:0]   pix_dat_i,
  output logic                 pix_ack_o,
  output logic                 flt_val_o,
  input  logic                 flt_rdy_i,
  output logic                 flt_head_o,
  output logic [DATA_WD-1:0]   flt_dat_o,
  output logic [DATA_WD-1:0]   flt_a_o,
  output logic [DATA_WD-1:0]   flt_b_o,
  output logic [DATA_WD-1:0]   flt_c_o,
  output logic                 lb_wr_val_o,
  output logic [DATA_WD-1:0]   lb_wr_dat_o,
  output logic                 lb_rd_ack_o,
  input  logic [DATA_WD-1:0]   lb_rd_dat_i,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_ROW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [SIZE_W_WD-1:0] COL_ONE = {{(SIZE_W_WD-1){1'b0}}, 1'b1};
  localparam logic [SIZE_H_WD-1:0] ROW_ONE = {{(SIZE_H_WD-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SIZE_W_WD-1:0] r_col;
  logic [SIZE_H_WD-1:0] r_row;
  logic [DATA_WD-1:0]   r_a;
  logic [DATA_WD-1:0]   r_c;
  logic [SIZE_W_WD-1:0] r_cfg_w;
  logic [SIZE_H_WD-1:0] r_cfg_h;
  logic [2:0]           r_cfg_flt;

  logic                 w_xfer;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_col_zero;
  logic                 w_row_zero;
  logic [DATA_WD-1:0]   w_b;
  logic                 w_start;

  assign w_start    = (r_state == S_IDLE) && start_i;
  assign w_xfer     = (r_state == S_ROW) && pix_val_i && flt_rdy_i;
  assign w_col_last = (r_col == r_cfg_w);
  assign w_row_last = (r_row == r_cfg_h);
  assign w_col_zero = (r_col == '0);
  assign w_row_zero = (r_row == '0);
  // The first row has no row above it, so "up" reads as zero.
  assign w_b        = w_row_zero ? '0 : lb_rd_dat_i;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_HEAD;
      S_HEAD: if (flt_rdy_i) w_state_nxt = S_ROW;
      S_ROW: begin
        if (w_xfer && w_col_last) begin
          w_state_nxt = w_row_last ? S_DONE : S_HEAD;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: configuration, position counters, neighbour history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col     <= '0;
      r_row     <= '0;
      r_a       <= '0;
      r_c       <= '0;
      r_cfg_w   <= '0;
      r_cfg_h   <= '0;
      r_cfg_flt <= '0;
    end else begin
      if (w_start) begin
        r_cfg_w   <= cfg_w_i;
        r_cfg_h   <= cfg_h_i;
        // Types above Paeth are not valid PNG filters; fall back to None.
        r_cfg_flt <= (cfg_flt_i > 3'd4) ? 3'd0 : cfg_flt_i;
        r_col     <= '0;
        r_row     <= '0;
      end else if ((r_state == S_HEAD) && flt_rdy_i) begin
        r_col <= '0;
      end else if (w_xfer) begin
        // a is the pixel just sent; c is the up value that went with it,
        // which is exactly the up-left of the next pixel in this row.
        r_a <= pix_dat_i;
        r_c <= w_b;
        if (w_col_last) begin
          r_col <= '0;
          if (!w_row_last) r_row <= r_row + ROW_ONE;
        end else begin
          r_col <= r_col + COL_ONE;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    busy_o      = (r_state != S_IDLE);
    done_o      = 1'b0;
    pix_ack_o   = 1'b0;
    flt_val_o   = 1'b0;
    flt_head_o  = 1'b0;
    flt_dat_o   = '0;
    flt_a_o     = '0;
    flt_b_o     = '0;
    flt_c_o     = '0;
    lb_wr_val_o = 1'b0;
    lb_wr_dat_o = '0;
    lb_rd_ack_o = 1'b0;
    case (r_state)
      S_HEAD: begin
        flt_val_o  = 1'b1;
        flt_head_o = 1'b1;
        flt_dat_o  = {{(DATA_WD-3){1'b0}}, r_cfg_flt};
      end
      S_ROW: begin
        flt_val_o   = pix_val_i;
        pix_ack_o   = w_xfer;
        flt_dat_o   = pix_dat_i;
        flt_a_o     = w_col_zero ? '0 : r_a;
        flt_b_o     = w_b;
        flt_c_o     = (w_col_zero || w_row_zero) ? '0 : r_c;
        // The last row is never needed as an "up" row; the first row has
        // nothing stored above it to consume.
        lb_wr_val_o = w_xfer && !w_row_last;
        lb_wr_dat_o = pix_dat_i;
        lb_rd_ack_o = w_xfer && !w_row_zero;
      end
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_flt_row_ctrl.sv
module tb_flt_row_ctrl;

  localparam int DW = 8;
  localparam int WW = 12;
  localparam int HW = 12;

  typedef struct packed {
    logic          head;
    logic [DW-1:0] pix;   // source pixel (also expected data), or type on a head beat
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          start_i = 1'b0;
  logic [WW-1:0] cfg_w_i = '0;
  logic [HW-1:0] cfg_h_i = '0;
  logic [2:0]    cfg_flt_i = '0;
  logic          busy_o, done_o;
  logic          pix_val_i = 1'b0;
  logic [DW-1:0] pix_dat_i = '0;
  logic          pix_ack_o;
  logic          flt_val_o;
  logic          flt_rdy_i = 1'b1;
  logic          flt_head_o;
  logic [DW-1:0] flt_dat_o, flt_a_o, flt_b_o, flt_c_o;
  logic          lb_wr_val_o;
  logic [DW-1:0] lb_wr_dat_o;
  logic          lb_rd_ack_o;
  logic [DW-1:0] lb_rd_dat_i = '0;
  logic [1:0]    dbg_state_o;

  flt_row_ctrl #(.DATA_WD(DW), .SIZE_W_WD(WW), .SIZE_H_WD(HW)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i),
    .cfg_w_i(cfg_w_i), .cfg_h_i(cfg_h_i), .cfg_flt_i(cfg_flt_i),
    .busy_o(busy_o), .done_o(done_o),
    .pix_val_i(pix_val_i), .pix_dat_i(pix_dat_i), .pix_ack_o(pix_ack_o),
    .flt_val_o(flt_val_o), .flt_rdy_i(flt_rdy_i), .flt_head_o(flt_head_o),
    .flt_dat_o(flt_dat_o), .flt_a_o(flt_a_o), .flt_b_o(flt_b_o), .flt_c_o(flt_c_o),
    .lb_wr_val_o(lb_wr_val_o), .lb_wr_dat_o(lb_wr_dat_o),
    .lb_rd_ack_o(lb_rd_ack_o), .lb_rd_dat_i(lb_rd_dat_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int            n_chk = 0;
  int            n_fail = 0;
  vec_t          tbl[$];             // stimulus/expected table for one image
  logic [32:0]   exp_q[$];           // expected beats
  logic [32:0]   got_q[$];           // observed beats
  logic [DW-1:0] src_q[$];           // pending source pixels
  logic [DW-1:0] lb_q[$];            // line buffer model (FIFO, pre-read head)
  int            cyc = 0;
  int            wr_cnt = 0, rd_cnt = 0, done_cnt = 0, bad_ack = 0;
  int            last_xfer_cyc = 0, done_cyc = 0;
  logic          tog = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor + source/line-buffer driver: observe at negedge, drive 1ns after posedge.
  always begin : mon
    logic          p_src_pop, p_lb_pop, p_lb_push;
    logic [DW-1:0] p_dat;
    @(negedge clk);
    cyc++;
    p_src_pop = 1'b0; p_lb_pop = 1'b0; p_lb_push = 1'b0; p_dat = '0;
    if (rstn) begin
      if (flt_val_o && flt_rdy_i) begin
        got_q.push_back({flt_head_o, flt_dat_o, flt_a_o, flt_b_o, flt_c_o});
        last_xfer_cyc = cyc;
      end
      if (pix_ack_o) begin
        p_src_pop = 1'b1;
        if (!flt_rdy_i) bad_ack++;
      end
      if (lb_wr_val_o) begin wr_cnt++; p_lb_push = 1'b1; p_dat = lb_wr_dat_o; end
      if (lb_rd_ack_o) begin rd_cnt++; p_lb_pop = 1'b1; end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
    end
    @(posedge clk);
    #1;
    if (p_src_pop && src_q.size() > 0) void'(src_q.pop_front());
    if (p_lb_pop && lb_q.size() > 0) void'(lb_q.pop_front());
    if (p_lb_push) lb_q.push_back(p_dat);
    pix_val_i   = (src_q.size() != 0);
    pix_dat_i   = (src_q.size() != 0) ? src_q[0] : '0;
    lb_rd_dat_i = (lb_q.size() != 0) ? lb_q[0] : '0;
    flt_rdy_i   = tog ? ~flt_rdy_i : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic add(input logic h, input int p, input int a, input int b, input int c);
    vec_t v;
    v.head = h; v.pix = p[DW-1:0]; v.a = a[DW-1:0]; v.b = b[DW-1:0]; v.c = c[DW-1:0];
    tbl.push_back(v);
  endtask

  task automatic load_tbl();
    exp_q.delete();
    got_q.delete();
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i]);
      if (!tbl[i].head) src_q.push_back(tbl[i].pix);
    end
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; bad_ack = 0;
  endtask

  task automatic kick(input int w, input int h, input int f);
    step();
    cfg_w_i = w[WW-1:0]; cfg_h_i = h[HW-1:0]; cfg_flt_i = f[2:0];
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic run_image(input string nm, input int w, input int h, input int f,
                           input int exp_lb);
    int n;
    int d0;
    load_tbl();
    kick(w, h, f);
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 400) begin step(); n++; end
    chk({nm, "_done_seen"}, (done_cnt != d0), 1);
    step(); step();
    chk({nm, "_beat_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), got_q[i], exp_q[i]);
    chk({nm, "_lb_writes"}, wr_cnt, exp_lb);
    chk({nm, "_lb_reads"}, rd_cnt, exp_lb);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_done_after_last_xfer"}, done_cyc - last_xfer_cyc, 1);
    chk({nm, "_ack_while_not_ready"}, bad_ack, 0);
    chk({nm, "_idle_after"}, {busy_o, done_o, flt_val_o}, 0);
  endtask

  task automatic tbl_t1(input int f);
    tbl.delete();
    add(1, f, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 2, 1, 0, 0); add(0, 3, 2, 0, 0); add(0, 4, 3, 0, 0);
    add(1, f, 0, 0, 0); add(0, 5, 0, 1, 0); add(0, 6, 5, 2, 1); add(0, 7, 6, 3, 2); add(0, 8, 7, 4, 3);
  endtask

  function automatic logic [63:0] all_outs();
    return {busy_o, done_o, pix_ack_o, flt_val_o, flt_head_o, lb_wr_val_o, lb_rd_ack_o,
            flt_dat_o, flt_a_o, flt_b_o, flt_c_o, lb_wr_dat_o};
  endfunction

  // ---------------- test sequence ----------------
  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", all_outs(), 0);
    chk("reset_state", dbg_state_o, 0);
    rstn = 1'b1;
    step();
    chk("idle_outputs", all_outs(), 0);

    // Basic 4x2 image, Sub filter
    tbl_t1(1);
    run_image("t1", 3, 1, 1, 4);

    // 3x3 image, Paeth, flt_rdy_i toggling every cycle
    tbl.delete();
    add(1, 4, 0, 0, 0);   add(0, 10, 0, 0, 0);   add(0, 11, 10, 0, 0);  add(0, 12, 11, 0, 0);
    add(1, 4, 0, 0, 0);   add(0, 13, 0, 10, 0);  add(0, 14, 13, 11, 10); add(0, 15, 14, 12, 11);
    add(1, 4, 0, 0, 0);   add(0, 16, 0, 13, 0);  add(0, 17, 16, 14, 13); add(0, 18, 17, 15, 14);
    tog = 1'b1;
    run_image("t2", 2, 2, 4, 6);
    tog = 1'b0;
    step(); step();

    // 1x1 image, illegal type 6 falls back to None
    tbl.delete();
    add(1, 0, 0, 0, 0); add(0, 9, 0, 0, 0);
    run_image("t3", 0, 0, 6, 0);

    // Start pulse and cfg changes mid-image must be ignored
    tbl.delete();
    add(1, 2, 0, 0, 0); add(0, 21, 0, 0, 0);  add(0, 22, 21, 0, 0);  add(0, 23, 22, 0, 0);  add(0, 24, 23, 0, 0);
    add(1, 2, 0, 0, 0); add(0, 25, 0, 21, 0); add(0, 26, 25, 22, 21); add(0, 27, 26, 23, 22); add(0, 28, 27, 24, 23);
    fork
      run_image("t4", 3, 1, 2, 4);
      begin
        repeat (6) step();
        start_i = 1'b1; cfg_w_i = '0; cfg_h_i = '0; cfg_flt_i = 3'd3;
        step();
        start_i = 1'b0;
      end
    join
    step(); step();
    chk("t4_no_restart", {busy_o, 24'(got_q.size())}, {1'b0, 24'd10});

    // Reset asserted in the middle of row 1
    tbl_t1(1);
    load_tbl();
    kick(3, 1, 1);
    n = 0;
    while (got_q.size() < 7 && n < 200) begin step(); n++; end
    chk("t5_reached_row1", (got_q.size() >= 7), 1);
    rstn = 1'b0;
    step();
    chk("t5_reset_outputs", all_outs(), 0);
    chk("t5_reset_state", dbg_state_o, 0);
    chk("t5_no_done", done_cnt, 0);
    src_q.delete(); lb_q.delete(); got_q.delete();
    pix_val_i = 1'b0; pix_dat_i = '0; lb_rd_dat_i = '0;
    step();
    rstn = 1'b1;
    step();
    tbl_t1(1);
    run_image("t5_rerun", 3, 1, 1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
